i2c_target_mem: RTL

I2C target (responder) with a 256-byte internal register memory, sitting at the far end of the SoC's I2C master on the same open-drain SCL/SDA pair. It decodes START, repeated START and STOP, matches a 7-bit device address, and accepts a word address. It then stores written bytes or returns read bytes with auto-increment. It serves as the in-system peer and bench model for byte, random, page-write and page-read transactions.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_bus_sync.sv | 54 +++++
 rtl/i2c_target_mem.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-memory target.
//   i2c_state_t      : protocol FSM states
//   ACK / NACK       : SDA levels of the acknowledge bit
//   DEV_ADDR_DEFAULT : 7-bit device address answered by default (R/W bit excluded)
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_WADDR,
        ST_WADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h57;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the asynchronous SCL/SDA pair into the clk domain and decodes bus events.
//   clk, n_rst : system clock, async active-low reset
//   scl, sda_i : raw bus levels
//   scl_rise   : one-clk pulse on a synchronized SCL rising edge
//   scl_fall   : one-clk pulse on a synchronized SCL falling edge
//   start_det  : one-clk pulse, SDA fell while SCL high
//   stop_det   : one-clk pulse, SDA rose while SCL high
//   sda_s      : synchronized SDA, aligned with the event pulses
// Pin edge to event pulse is 3 clk. Reset values model an idle (released) bus so
// leaving reset never produces a spurious event.
module i2c_bus_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic scl,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl};
            sda_sync  <= {sda_sync[0], sda_i};
            scl_d     <= scl_sync[1];
            sda_d     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_d;
            scl_fall  <= ~scl_sync[1] & scl_d;
            // SCL must be high on both sides of the SDA edge, so SDA activity
            // during SCL low (or coincident with an SCL edge) is never a START/STOP.
            start_det <= scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
            sda_s     <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a 256x8 register memory, auto-incrementing pointer.
//   clk, n_rst : system clock, async active-low reset
//   scl, sda_i : bus inputs (SCL never stretched)
//   sda_oe     : 1 pulls SDA low, 0 releases it
//   wr_valid   : one-clk pulse per byte committed to memory
//   wr_addr    : address of the committed byte
//   wr_data    : committed byte
//   busy       : addressed transaction in progress
//
// state        | meaning
// ST_IDLE      | bus free or after STOP
// ST_DEV       | shifting in device address + R/W
// ST_DEV_ACK   | driving ACK for a matched device address
// ST_WADDR     | shifting in word address
// ST_WADDR_ACK | driving ACK for the word address
// ST_WDATA     | shifting in a write data byte
// ST_WDATA_ACK | driving ACK; byte committed at the ACK's SCL fall
// ST_RDATA     | driving a read byte MSB-first
// ST_RDATA_ACK | SDA released, sampling master ACK/NACK
// ST_WAIT_STOP | not addressed or read ended; ignore until START/STOP
module i2c_target_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .n_rst     (n_rst),
        .scl       (scl),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_t state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic       byte_full, byte_full_nx;
    logic [7:0] shift, shift_nx;
    logic [7:0] ptr, ptr_nx;
    logic       sda_oe_nx;
    logic       busy_nx;
    logic       wr_valid_nx;
    logic [7:0] wr_addr_nx;
    logic [7:0] wr_data_nx;
    logic       mem_we;

    logic [7:0] mem [256];
    logic [7:0] mem_rd;

    assign mem_rd = mem[ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd7;
            byte_full <= 1'b0;
            shift     <= 8'h00;
            ptr       <= 8'h00;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            byte_full <= byte_full_nx;
            shift     <= shift_nx;
            ptr       <= ptr_nx;
            sda_oe    <= sda_oe_nx;
            busy      <= busy_nx;
            wr_valid  <= wr_valid_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
        end
    end

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= shift;
        end
    end

    // byte_full marks that the 8th bit has been clocked in (or out); the next
    // SCL fall is the start of the ACK bit.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        byte_full_nx = byte_full;
        shift_nx     = shift;
        ptr_nx       = ptr;
        sda_oe_nx    = sda_oe;
        busy_nx      = busy;
        wr_valid_nx  = 1'b0;
        wr_addr_nx   = wr_addr;
        wr_data_nx   = wr_data;
        mem_we       = 1'b0;

        if (stop_det) begin
            state_nx     = ST_IDLE;
            sda_oe_nx    = 1'b0;
            busy_nx      = 1'b0;
            byte_full_nx = 1'b0;
        end else if (start_det) begin
            state_nx     = ST_DEV;
            bit_cnt_nx   = 3'd7;
            byte_full_nx = 1'b0;
            sda_oe_nx    = 1'b0;
        end else begin
            case (state)
                ST_DEV, ST_WADDR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_nx = {shift[6:0], sda_s};
                        if (bit_cnt == 3'd0) begin
                            byte_full_nx = 1'b1;
                        end else begin
                            bit_cnt_nx = bit_cnt - 3'd1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nx = 1'b0;
                        case (state)
                            ST_DEV: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_nx  = ST_DEV_ACK;
                                    sda_oe_nx = ~ACK;
                                    busy_nx   = 1'b1;
                                end else begin
                                    state_nx = ST_WAIT_STOP;
                                    busy_nx  = 1'b0;
                                end
                            end
                            ST_WADDR: begin
                                ptr_nx    = shift;
                                state_nx  = ST_WADDR_ACK;
                                sda_oe_nx = ~ACK;
                            end
                            default: begin
                                state_nx  = ST_WDATA_ACK;
                                sda_oe_nx = ~ACK;
                            end
                        endcase
                    end
                end

                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nx = 3'd7;
                        if (shift[0]) begin
                            state_nx  = ST_RDATA;
                            shift_nx  = {mem_rd[6:0], 1'b0};
                            sda_oe_nx = ~mem_rd[7];
                        end else begin
                            state_nx  = ST_WADDR;
                            sda_oe_nx = 1'b0;
                        end
                    end
                end

                ST_WADDR_ACK: begin
                    if (scl_fall) begin
                        state_nx   = ST_WDATA;
                        bit_cnt_nx = 3'd7;
                        sda_oe_nx  = 1'b0;
                    end
                end

                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        mem_we      = 1'b1;
                        wr_valid_nx = 1'b1;
                        wr_addr_nx  = ptr;
                        wr_data_nx  = shift;
                        ptr_nx      = ptr + 8'd1;
                        state_nx    = ST_WDATA;
                        bit_cnt_nx  = 3'd7;
                        sda_oe_nx   = 1'b0;
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt == 3'd0) begin
                            byte_full_nx = 1'b1;
                        end else begin
                            bit_cnt_nx = bit_cnt - 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (byte_full) begin
                            byte_full_nx = 1'b0;
                            sda_oe_nx    = 1'b0;
                            state_nx     = ST_RDATA_ACK;
                        end else begin
                            sda_oe_nx = ~shift[7];
                            shift_nx  = {shift[6:0], 1'b0};
                        end
                    end
                end

                // Pointer advances at the ACK rise so the reload at the following
                // fall already sees the next location.
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_nx = ptr + 8'd1;
                        if (sda_s == NACK) begin
                            state_nx = ST_WAIT_STOP;
                            busy_nx  = 1'b0;
                        end else begin
                            byte_full_nx = 1'b1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nx = 1'b0;
                        state_nx     = ST_RDATA;
                        bit_cnt_nx   = 3'd7;
                        shift_nx     = {mem_rd[6:0], 1'b0};
                        sda_oe_nx    = ~mem_rd[7];
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
